// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// busy while working, one-cycle div_done pulse with result and rd. Only XLEN = 32 is supported.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic [2:0]      div_op,
  input  logic            is_div_instruction,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            div_done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic            op_rem;
  logic            q_neg;
  logic            r_neg;
  logic            div_zero;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] b_mag;
  logic [CW-1:0]   count;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;

  logic            accept;
  logic            signed_in;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] quo_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] final_val;

  assign dbg_state = state;

  // Handshake: a request is the level div_start & is_div_instruction & div_op[2],
  // taken only in IDLE; anything seen in CALC or DONE is dropped, not queued.
  always_comb begin
    accept    = (state == IDLE) && div_start && is_div_instruction && div_op[2];
    signed_in = ~div_op[0];
    a_mag_in  = (signed_in && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    b_mag_in  = (signed_in && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
  end

  // One restoring step: shift the next dividend bit in from quo, then trial-subtract.
  always_comb begin
    rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
    quo_sh = {quo[XLEN-2:0], 1'b0};
    trial  = rem_sh - {1'b0, b_mag};
  end

  always_comb begin
    q_fix = q_neg ? (~quo + 1'b1) : quo;
    r_fix = r_neg ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    if (div_zero) begin
      final_val = op_rem ? a_raw : {XLEN{1'b1}};
    end else begin
      final_val = op_rem ? r_fix : q_fix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      div_done <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
      op_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      b_mag    <= '0;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
    end else begin
      div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_rem   <= div_op[1];
            rd_out   <= rd_in;
            q_neg    <= signed_in & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_neg    <= signed_in & dividend[XLEN-1];
            div_zero <= (divisor == '0);
            a_raw    <= dividend;
            b_mag    <= b_mag_in;
            count    <= '0;
            rem      <= '0;
            quo      <= a_mag_in;
            busy     <= 1'b1;
            state    <= (divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          if (!trial[XLEN]) begin
            rem <= trial;
            quo <= quo_sh | {{(XLEN-1){1'b0}}, 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= quo_sh;
          end
          count <= count + 1'b1;
          if (count == CW'(XLEN - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          result   <= final_val;
          div_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: table of divide vectors plus hand-written sequences for
// in-flight noise, rejected requests and mid-calculation reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic [2:0]  div_op;
  logic        is_div_instruction;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_in;
  logic        busy;
  logic        div_done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  vec_t vecs[13];

  div_unit #(.XLEN(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .div_start          (div_start),
    .div_op             (div_op),
    .is_div_instruction (is_div_instruction),
    .dividend           (dividend),
    .divisor            (divisor),
    .rd_in              (rd_in),
    .busy               (busy),
    .div_done           (div_done),
    .result             (result),
    .rd_out             (rd_out),
    .dbg_state          (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every div_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && div_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result=%h rd=%0d want no done", result, rd_out);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e[31:0]);
        check("rd_out", {27'b0, rd_out}, {27'b0, e[36:32]});
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input bit noise);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    div_start          = 1'b1;
    is_div_instruction = 1'b1;
    div_op             = op;
    dividend           = a;
    divisor            = b;
    rd_in              = rd;
    exp_q.push_back({rd, exp});
    @(posedge clk);
    #1;
    if (!noise) begin
      div_start = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      rd_in     = 5'($urandom_range(0, 31));
    end
    cyc = 0;
    busy_cnt = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (div_done) break;
      if (busy) busy_cnt++;
      cyc++;
      if (noise) begin
        if (cyc < 25) begin
          div_start          = 1'b1;
          is_div_instruction = 1'b1;
          div_op             = 3'b100 | 3'($urandom_range(0, 3));
          dividend           = $urandom;
          divisor            = $urandom_range(0, 5);
          rd_in              = 5'($urandom_range(0, 31));
        end else begin
          div_start = 1'b0;
        end
      end
    end
    check("latency", 32'(cyc), 32'(lat));
    check("busy_cycles", 32'(busy_cnt), 32'(lat));
    check("busy_low_at_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("done_single_pulse", {31'b0, div_done}, 32'd0);
    div_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33};
    vecs[1]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          5'd1,  32'hFFFFFFFD,   33};
    vecs[2]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          5'd2,  32'hFFFFFFFF,   33};
    vecs[3]  = '{OP_REM,  32'd7,          32'hFFFFFFFE,   5'd3,  32'd1,          33};
    vecs[4]  = '{OP_REMU, 32'hFFFFFFFF,   32'd16,         5'd4,  32'd15,         33};
    vecs[5]  = '{OP_DIV,  32'h1234,       32'd0,          5'd6,  32'hFFFFFFFF,   1};
    vecs[6]  = '{OP_REM,  32'h1234,       32'd0,          5'd7,  32'h1234,       1};
    vecs[7]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd8,  32'h80000000,   33};
    vecs[8]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   5'd9,  32'd0,          33};
    vecs[9]  = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'd0,          33};
    vecs[10] = '{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'h80000000,   33};
    vecs[11] = '{OP_DIV,  32'd100,        32'hFFFFFFF9,   5'd31, 32'hFFFFFFF2,   33};
    vecs[12] = '{OP_DIVU, 32'hFFFFFFFF,   32'd0,          5'd12, 32'hFFFFFFFF,   1};

    rst                = 1'b1;
    div_start          = 1'b0;
    div_op             = 3'b000;
    is_div_instruction = 1'b0;
    dividend           = '0;
    divisor            = '0;
    rd_in              = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, div_done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", {27'b0, rd_out}, 32'd0);
    check("reset_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, 1'b0);
    end

    // New requests and operand changes during CALC must not disturb the running divide.
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, 1'b1);

    // Requests that fail qualification are never accepted.
    @(negedge clk);
    div_start = 1'b1; is_div_instruction = 1'b0; div_op = OP_DIVU;
    dividend = 32'd50; divisor = 32'd5;
    repeat (4) begin
      @(negedge clk);
      check("no_accept_not_div", {31'b0, busy}, 32'd0);
    end
    is_div_instruction = 1'b1; div_op = 3'b000;
    repeat (4) begin
      @(negedge clk);
      check("no_accept_op000", {31'b0, busy}, 32'd0);
    end
    div_start = 1'b0;

    // Reset at CALC step 10 discards the operation.
    @(negedge clk);
    div_start = 1'b1; is_div_instruction = 1'b1; div_op = OP_DIVU;
    dividend = 32'd1000; divisor = 32'd7; rd_in = 5'd9;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, div_done}, 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_rd", {27'b0, rd_out}, 32'd0);
    check("midreset_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_idle", {31'b0, busy}, 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd13, 32'd3, 33, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
